fht_stream_ctrl: RTL and testbench
==================================

FHT_STREAM_CTRL -- requirements
Module: fht_stream_ctrl

Interface
REQ-001 Parameter D_BIT, default `D_BIT (16): width of a transformed point; input samples are D_BIT-1 bits wide.
REQ-002 Parameter A_BIT, default `A_BIT: per-bank address width; transform size N = 4*2^A_BIT.
REQ-003 Parameter RD_LAT, default 1: FHT RAM read latency in clocks, from oFHT_ADDR_RD_x to iFHT_DATA_x.
REQ-004 Ports are as follows; one clock; iRESET is asynchronous and active-high.
- iCLK  in  1  clock
- iRESET  in  1  async active-high reset
- iS_DATA  in  D_BIT-1  ADC sample
- iS_VALID  in  1  sample valid
- oS_READY  out  1  sample accepted when high with iS_VALID
- oFHT_DATA  out  D_BIT-1  sample to FHT RAM(A)
- oFHT_ADDR_WR  out  A_BIT  bank write address
- oFHT_WE_0..3  out  1 each  bank-select write enables
- oFHT_START  out  1  one-cycle start strobe
- iFHT_RDY  in  1  FHT transform-done level
- oFHT_ADDR_RD_0..3  out  A_BIT each  bank read addresses
- iFHT_DATA_0..3  in  D_BIT each, signed  bank read data
- oM_DATA  out  D_BIT, signed  result point
- oM_VALID  out  1  result valid
- iM_READY  in  1  downstream ready
- oM_LAST  out  1  marks point N-1
- oBUSY  out  1  high in every state except LOAD

Function
REQ-005 The block SHALL implement the states LOAD, START, WAIT_BUSY, WAIT_DONE and UNLOAD.
REQ-006 Point index n (0..N-1) SHALL map to bank n[1:0] at address n[A_BIT+1:2], for both load and unload.
REQ-007 In LOAD, oS_READY SHALL be 1, and each iS_VALID&oS_READY cycle SHALL accept sample n and increment the load counter.
REQ-008 Writes SHALL be registered: in the cycle after sample n is accepted, oFHT_DATA=sample, oFHT_ADDR_WR=n>>2, and exactly the WE of bank n[1:0] SHALL be 1; all WEs SHALL otherwise be 0.
REQ-009 iS_VALID gaps SHALL stall the counter, with no WE asserted.
REQ-010 Acceptance of sample N-1 SHALL drop oS_READY the next cycle and move to START.
REQ-011 oFHT_START SHALL be 1 for exactly one cycle, the cycle after the final WE; the next state SHALL be WAIT_BUSY.
REQ-012 WAIT_BUSY SHALL advance to WAIT_DONE once iFHT_RDY=0; this rejects a stale RDY from the previous transform.
REQ-013 WAIT_DONE SHALL advance to UNLOAD when iFHT_RDY=1.
REQ-014 UNLOAD SHALL drive all four oFHT_ADDR_RD_x with n>>2 and capture iFHT_DATA_[n[1:0]] RD_LAT cycles later into the output FIFO.
REQ-015 A read SHALL issue only when FIFO occupancy plus reads in flight is less than the FIFO depth (RD_LAT+3); no result is ever dropped or duplicated.
REQ-016 Output SHALL follow the valid/ready rule: oM_DATA and oM_LAST stay stable while oM_VALID=1 and iM_READY=0; a transfer occurs when both are 1.
REQ-017 With iM_READY held at 1, throughput SHALL be one point per clock after a first-point latency of RD_LAT+1 clocks from UNLOAD entry.
REQ-018 oM_LAST SHALL be 1 only with point N-1.
REQ-019 The transfer of point N-1 SHALL return the block to LOAD with counters at 0; oS_READY SHALL be 1 on the next cycle.
REQ-020 Outside UNLOAD, oFHT_ADDR_RD_x SHALL be 0.
REQ-021 oM_DATA SHALL pass through unmodified: signed, D_BIT wide, with no rescaling.
REQ-022 Counters SHALL be A_BIT+2 bits wide, and N-1 is the terminal count; no wrap occurs without a state change.

Reset
REQ-023 iRESET=1 SHALL asynchronously force state LOAD, clear all counters and the FIFO, and set every output to 0, including oS_READY.
REQ-024 In the first clock after iRESET deasserts, oS_READY SHALL become 1.
REQ-025 Reset asserted mid-load, mid-wait or mid-unload SHALL abandon the frame; the partial frame is never completed or emitted.

Structure
REQ-026 D_BIT, A_BIT and the RAM read latency SHALL come from fht_defines.v; state encodings are local parameters.
REQ-027 The output FIFO SHALL be a sub-module, fht_out_fifo (depth RD_LAT+3, with full/empty/count outputs).

Verification
REQ-028 Config A_BIT=2 (N=16), RD_LAT=1: samples 0..15 streamed continuously -> WE pattern 0,1,2,3 repeating, ADDR_WR 0,0,0,0,1..3,3, and oFHT_START exactly 1 cycle after the 16th WE.
REQ-029 iS_VALID toggled every other cycle -> 16 WEs total, with no WE in gap cycles.
REQ-030 iFHT_RDY held 1 when START issues, dropped after 5 cycles and raised after 20 -> UNLOAD entered only after the rise.
REQ-031 Model RAM holding value 100+n, with iM_READY=1 -> oM_DATA 100..115 on consecutive cycles, and oM_LAST only with 115.
REQ-032 Random iM_READY (50%) -> the same 16 values in order, with data held stable during stalls.
REQ-033 iRESET pulsed after 7 samples -> all outputs 0 at once, oS_READY=1 next cycle, and a fresh 16-sample frame processes correctly.

Source files
------------

// File: rtl/fht_stream_ctrl_pkg.sv
// Shared build constants and helpers for the FHT streaming controller.
// The defaults take the place of the legacy fht_defines.v macros.
package fht_stream_ctrl_pkg;

   localparam int FHT_D_BIT  = 16;
   localparam int FHT_A_BIT  = 2;
   localparam int FHT_RD_LAT = 1;

   function automatic logic [3:0] bank_we(input logic [1:0] bank);
      return 4'b0001 << bank;
   endfunction

endpackage

// File: rtl/fht_stream_ctrl_if.sv
// Sample stream, FHT RAM access and result stream of the FHT controller.
interface fht_stream_ctrl_if
   import fht_stream_ctrl_pkg::*;
#(
   parameter int D_BIT = FHT_D_BIT,
   parameter int A_BIT = FHT_A_BIT
);
   logic        [D_BIT-2:0] s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic        [D_BIT-2:0] fht_data;
   logic        [A_BIT-1:0] fht_addr_wr;
   logic              [3:0] fht_we;
   logic                    fht_start;
   logic                    fht_rdy;
   logic        [A_BIT-1:0] fht_addr_rd [4];
   logic signed [D_BIT-1:0] fht_rd_data [4];
   logic signed [D_BIT-1:0] m_data;
   logic                    m_valid;
   logic                    m_ready;
   logic                    m_last;
   logic                    busy;

   modport master (
      input  s_data, s_valid, fht_rdy, fht_rd_data, m_ready,
      output s_ready, fht_data, fht_addr_wr, fht_we, fht_start, fht_addr_rd,
             m_data, m_valid, m_last, busy
   );

   modport slave (
      output s_data, s_valid, fht_rdy, fht_rd_data, m_ready,
      input  s_ready, fht_data, fht_addr_wr, fht_we, fht_start, fht_addr_rd,
             m_data, m_valid, m_last, busy
   );
endinterface

// File: rtl/fht_out_fifo.sv
// Small result FIFO with show-ahead output; head reads as zero while empty.
module fht_out_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               pop_data,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/fht_stream_ctrl.sv
// Loads one N-point frame into four FHT RAM banks, starts the transform,
// waits for completion and streams the results out through a small FIFO.
module fht_stream_ctrl
   import fht_stream_ctrl_pkg::*;
#(
   parameter int D_BIT  = FHT_D_BIT,
   parameter int A_BIT  = FHT_A_BIT,
   parameter int RD_LAT = FHT_RD_LAT
) (
   input logic                iCLK,
   input logic                iRESET,
   fht_stream_ctrl_if.master  bus
);
   localparam logic [2:0] LOAD      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] WAIT_BUSY = 3'd2;
   localparam logic [2:0] WAIT_DONE = 3'd3;
   localparam logic [2:0] UNLOAD    = 3'd4;

   localparam int DEPTH = RD_LAT + 3;
   localparam int CW    = A_BIT + 2;
   localparam int FW    = D_BIT + 1;
   localparam int OCW   = $clog2(DEPTH + 1);
   localparam int PBW   = 2 * RD_LAT;

   logic [2:0]              state, state_nx;
   logic [CW-1:0]           ld_cnt, rd_cnt;
   logic                    rd_done;
   logic                    s_ready;
   logic                    accept, issue, xfer, xfer_last;
   logic [RD_LAT-1:0]       pv, plast;
   logic [RD_LAT-1:0][1:0]  pbank;
   logic [FW-1:0]           fifo_in, fifo_out;
   logic                    fifo_full, fifo_empty;
   logic [OCW-1:0]          fifo_count;

   assign accept    = s_ready && bus.s_valid;
   assign xfer      = bus.m_valid && bus.m_ready;
   assign xfer_last = xfer && bus.m_last;

   // Occupancy plus reads still in the RAM pipeline bounds issue, so every
   // read has a FIFO slot waiting when its data returns.
   always_comb begin
      issue = (state == UNLOAD) && !rd_done && !fifo_full &&
              ((int'(fifo_count) + $countones(pv)) < DEPTH);
   end

   always_comb begin
      state_nx = state;
      case (state)
         LOAD:      if (accept && ld_cnt == '1) state_nx = START;
         START:     state_nx = WAIT_BUSY;
         WAIT_BUSY: if (!bus.fht_rdy) state_nx = WAIT_DONE;
         WAIT_DONE: if (bus.fht_rdy) state_nx = UNLOAD;
         UNLOAD:    if (xfer_last) state_nx = LOAD;
         default:   state_nx = LOAD;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         state           <= LOAD;
         s_ready         <= 1'b0;
         ld_cnt          <= '0;
         rd_cnt          <= '0;
         rd_done         <= 1'b0;
         bus.fht_data    <= '0;
         bus.fht_addr_wr <= '0;
         bus.fht_we      <= '0;
         bus.fht_start   <= 1'b0;
         pv              <= '0;
         plast           <= '0;
         pbank           <= '0;
      end else begin
         state         <= state_nx;
         s_ready       <= (state_nx == LOAD);
         bus.fht_start <= (state == START);
         bus.fht_we    <= '0;
         if (accept) begin
            bus.fht_data    <= bus.s_data;
            bus.fht_addr_wr <= ld_cnt[CW-1:2];
            bus.fht_we      <= bank_we(ld_cnt[1:0]);
            ld_cnt          <= (ld_cnt == '1) ? '0 : ld_cnt + 1'b1;
         end
         if (issue) begin
            if (rd_cnt == '1) rd_done <= 1'b1;
            else              rd_cnt  <= rd_cnt + 1'b1;
         end
         pv    <= (pv << 1) | RD_LAT'(issue);
         plast <= (plast << 1) | RD_LAT'(issue && rd_cnt == '1);
         pbank <= (pbank << 2) | PBW'(rd_cnt[1:0]);
         if (xfer_last) begin
            rd_cnt  <= '0;
            rd_done <= 1'b0;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 4; i++) begin
         bus.fht_addr_rd[i] = (state == UNLOAD) ? rd_cnt[CW-1:2] : '0;
      end
   end

   assign fifo_in = {plast[RD_LAT-1], bus.fht_rd_data[pbank[RD_LAT-1]]};

   fht_out_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (iCLK),
      .rst       (iRESET),
      .push      (pv[RD_LAT-1]),
      .push_data (fifo_in),
      .pop       (xfer),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.s_ready = s_ready;
   assign bus.m_valid = !fifo_empty;
   assign bus.m_data  = fifo_out[D_BIT-1:0];
   assign bus.m_last  = fifo_out[D_BIT];
   assign bus.busy    = (state != LOAD);
endmodule

// File: tb/tb_fht_stream_ctrl.sv
// Scoreboard bench for fht_stream_ctrl with a behavioural FHT RAM/engine model.
module tb_fht_stream_ctrl;
   localparam int D_BIT  = 16;
   localparam int A_BIT  = 2;
   localparam int RD_LAT = 1;
   localparam int N      = 16;

   typedef struct packed {
      logic [1:0]       bank;
      logic [A_BIT-1:0] addr;
      logic [D_BIT-2:0] data;
   } wr_t;

   typedef struct packed {
      logic signed [D_BIT-1:0] data;
      logic                    last;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fht_stream_ctrl_if #(.D_BIT(D_BIT), .A_BIT(A_BIT)) bus();

   fht_stream_ctrl #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
      .iCLK   (clk),
      .iRESET (rst),
      .bus    (bus)
   );

   wr_t  wq[$];
   out_t oq[$];
   int   chk_cnt   = 0;
   int   pass_cnt  = 0;
   int   cyc       = 0;
   int   base      = 100;
   bit   rand_ready = 1'b0;
   int   rise_cyc  = -1000;
   int   frame_we  = 0;
   int   start_due = -1;
   logic signed [D_BIT-1:0] ram [4][4];

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RAM read port model, latency RD_LAT = 1
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) bus.fht_rd_data[b] <= ram[b][bus.fht_addr_rd[b]];
   end

   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // FHT engine: RDY stays high (stale) at START, drops after 5 clocks,
   // rises 20 clocks later with the RAM holding base+n.
   initial begin
      bus.fht_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst && bus.fht_start) begin
            repeat (5) @(posedge clk);
            #1 bus.fht_rdy = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            for (int n = 0; n < N; n++) ram[n % 4][n / 4] = 16'(base + n);
            bus.fht_rdy = 1'b1;
            rise_cyc = cyc;
         end
      end
   end

   // write-side monitor
   always @(negedge clk) begin
      wr_t e;
      if (rst) begin
         frame_we  = 0;
         start_due = -1;
      end else begin
         if (bus.fht_we != 4'b0000) begin
            if (wq.size() == 0) chk(1'b0, "unexpected_we", longint'(bus.fht_we), 0);
            else begin
               e = wq.pop_front();
               chk(bus.fht_we == (4'b0001 << e.bank), "we_onehot", longint'(bus.fht_we), longint'(4'b0001 << e.bank));
               chk(bus.fht_addr_wr == e.addr, "addr_wr", longint'(bus.fht_addr_wr), longint'(e.addr));
               chk(bus.fht_data == e.data, "wr_data", longint'(bus.fht_data), longint'(e.data));
               chk(bus.fht_addr_rd[0] == 0 && bus.fht_addr_rd[3] == 0, "addr_rd_idle",
                   longint'(bus.fht_addr_rd[0]), 0);
               frame_we++;
               if (frame_we == N) begin
                  start_due = cyc + 1;
                  frame_we  = 0;
               end
            end
         end
         if (bus.fht_start || cyc == start_due)
            chk(bus.fht_start && cyc == start_due, "start_strobe", bus.fht_start ? cyc : -1, start_due);
      end
   end

   // result-side monitor
   bit   prev_stall = 1'b0;
   logic signed [D_BIT-1:0] prev_data;
   logic prev_last;
   bit   seen_first = 1'b0;
   int   first_xfer = -1;
   bit   last_done  = 1'b0;

   always @(negedge clk) begin
      out_t o;
      if (rst) begin
         prev_stall = 1'b0;
         seen_first = 1'b0;
         last_done  = 1'b0;
      end else begin
         if (last_done) begin
            chk(bus.s_ready == 1'b1, "ready_after_last", longint'(bus.s_ready), 1);
            last_done = 1'b0;
         end
         if (prev_stall)
            chk(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last, "stall_hold",
                longint'(bus.m_data), longint'(prev_data));
         if (bus.m_valid && !seen_first) begin
            chk(cyc == rise_cyc + 3, "first_latency", cyc - rise_cyc, 3);
            seen_first = 1'b1;
            first_xfer = -1;
         end
         if (bus.m_valid && bus.m_ready) begin
            if (first_xfer < 0) first_xfer = cyc;
            if (oq.size() == 0) chk(1'b0, "unexpected_out", longint'(bus.m_data), 0);
            else begin
               o = oq.pop_front();
               chk(bus.m_data == o.data, "m_data", longint'(bus.m_data), longint'(o.data));
               chk(bus.m_last == o.last, "m_last", longint'(bus.m_last), longint'(o.last));
               if (o.last) begin
                  if (!rand_ready) chk(cyc - first_xfer == N - 1, "throughput", cyc - first_xfer, N - 1);
                  seen_first = 1'b0;
                  last_done  = 1'b1;
               end
            end
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
      end
   end

   task automatic send_frame(input int nsamp, input bit gaps, input int tag, input int b);
      int t = 0;
      while (!bus.s_ready && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      chk(bus.s_ready == 1'b1, "ready_before_frame", longint'(bus.s_ready), 1);
      base = b;
      for (int i = 0; i < nsamp; i++) begin
         wr_t e;
         logic [D_BIT-2:0] d;
         if (gaps && i > 0) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
         end
         d = 15'(tag * 1000 + i);
         bus.s_data  = d;
         bus.s_valid = 1'b1;
         e.bank = 2'(i % 4);
         e.addr = A_BIT'(i / 4);
         e.data = d;
         wq.push_back(e);
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      if (nsamp == N) begin
         for (int n = 0; n < N; n++) begin
            out_t o;
            o.data = 16'(b + n);
            o.last = (n == N - 1);
            oq.push_back(o);
         end
      end
   endtask

   task automatic wait_done();
      int t = 0;
      while ((oq.size() != 0 || !bus.s_ready) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk(oq.size() == 0 && bus.s_ready, "frame_complete", oq.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk(bus.s_ready == 1'b0, {tag, "_s_ready"}, longint'(bus.s_ready), 0);
      chk(bus.fht_we == 4'b0000 && !bus.fht_start, {tag, "_we_start"}, longint'({bus.fht_we, bus.fht_start}), 0);
      chk(bus.fht_data == 0 && bus.fht_addr_wr == 0, {tag, "_wr_bus"}, longint'(bus.fht_data), 0);
      chk(!bus.m_valid && bus.m_data == 0 && !bus.m_last, {tag, "_m_bus"}, longint'(bus.m_data), 0);
      chk(!bus.busy && bus.fht_addr_rd[0] == 0 && bus.fht_addr_rd[1] == 0 &&
          bus.fht_addr_rd[2] == 0 && bus.fht_addr_rd[3] == 0, {tag, "_busy_rd"}, longint'(bus.busy), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached with %0d/%0d passed", pass_cnt, chk_cnt);
      $fatal(1);
   end

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #1 rst = 1'b1;
      #1 check_zero("reset");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk(bus.s_ready == 1'b1, "ready_after_reset", longint'(bus.s_ready), 1);

      // continuous samples 0..15, downstream always ready
      rand_ready = 1'b0;
      send_frame(N, 1'b0, 0, 100);
      wait_done();

      // valid toggling, random downstream backpressure
      rand_ready = 1'b1;
      send_frame(N, 1'b1, 1, 100);
      wait_done();
      rand_ready = 1'b0;

      // reset after 7 samples abandons the frame
      send_frame(7, 1'b0, 2, 100);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_zero("abort");
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      chk(bus.s_ready == 1'b1, "ready_after_abort", longint'(bus.s_ready), 1);
      chk(wq.size() == 0, "abort_writes_drained", wq.size(), 0);

      // fresh frame with signed results -8..7
      send_frame(N, 1'b0, 3, -8);
      wait_done();
      chk(!bus.busy, "idle_busy", longint'(bus.busy), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
